sram_port_arbiter: RTL
======================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive port-A grants while port B waits before B is forced (1..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports a_valid/b_valid  input  1  request valid, port A (core) / port B (host).
REQ-005 SHALL have ports a_ready/b_ready  output  1  request accepted this cycle when valid&ready.
REQ-006 SHALL have ports a_we/b_we  input  1  1=write, 0=read.
REQ-007 SHALL have ports a_addr/b_addr  input  12  word address; [11:9] selects bank, [8:0] selects word.
REQ-008 SHALL have ports a_wdata/b_wdata  input  32  and a_wmask/b_wmask  input  4  write data and byte mask.
REQ-009 SHALL have ports a_done/b_done  output  1  one-cycle completion pulse, reads and writes.
REQ-010 SHALL have ports a_rdata/b_rdata  output  32  read data; valid only while the matching done is high.
REQ-011 SHALL have port ram_csb  output  8  per-bank chip select, active low.
REQ-012 SHALL have port ram_web  output  1  write enable, active low.
REQ-013 SHALL have ports ram_addr  output  9, ram_wdata  output  32, ram_wmask  output  4  shared bank-macro inputs.
REQ-014 SHALL have port ram_rdata  input  256  bank n read data at bits [32n+31:32n], valid the cycle after its csb was low.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> COMPLETE -> IDLE, one access per three cycles.
REQ-016 SHALL assert at most one of a_ready/b_ready, and only in IDLE; acceptance at edge k latches owner, we, addr, wdata, wmask.
REQ-017 In ISSUE (cycle k+1) SHALL drive ram_csb[latched bank]=0 (other bits 1), ram_web=~we, ram_addr/ram_wdata/ram_wmask from latched values.
REQ-018 In COMPLETE (cycle k+2) SHALL pulse the owner's done and drive owner's rdata = ram_rdata slice of latched bank for reads; rdata SHALL be 0 when done low or for writes.
REQ-019 Outside ISSUE SHALL hold ram_csb=8'hFF and ram_web=1; ram_addr/ram_wdata/ram_wmask hold last latched values.
REQ-020 Arbitration (fixed priority): A wins when both valid, unless starve counter == STARVE_LIMIT, then B wins.
REQ-021 Starve counter SHALL increment on each A acceptance while b_valid=1, clear on B acceptance, saturate at STARVE_LIMIT.
REQ-022 Valid deasserted before acceptance SHALL be dropped with no RAM access; no requirement that valid stay high.
REQ-023 A write with wmask=4'h0 SHALL still perform the ISSUE cycle with ram_wmask=0 and pulse done.
REQ-024 Requests arriving in ISSUE/COMPLETE SHALL wait; earliest next acceptance is cycle k+3.

Reset
REQ-025 reset SHALL asynchronously force IDLE, ram_csb=8'hFF, ram_web=1, ram_addr=0, ram_wdata=0, ram_wmask=0, ready=0, done=0, rdata=0, starve counter=0, round-robin pointer=A.
REQ-026 Reset during ISSUE or COMPLETE SHALL abort the access with no done pulse; first acceptance possible in the first IDLE cycle after release.

Configuration
REQ-027 With SRAM_ARB_RR_EN defined, SHALL arbitrate round-robin: when both valid, grant the port not granted last; starve counter and STARVE_LIMIT unused.
REQ-028 Without SRAM_ARB_RR_EN, SHALL use fixed priority with starvation counter per REQ-020/021.

Verification
REQ-029 A write addr 12'h203 data 32'hDEADBEEF mask 4'hF, then A read same -> ISSUE csb=8'hFD, ram_addr=9'h003, web=0; read a_done with a_rdata=32'hDEADBEEF from bank 1 slice.
REQ-030 A and B valid continuously, no macro -> grant order A,A,A,A,B,A,A,A,A,B; with SRAM_ARB_RR_EN -> A,B,A,B.
REQ-031 B read addr 12'hE00, bank 7 slice=32'h12345678 -> ram_csb=8'h7F in ISSUE, b_done with b_rdata=32'h12345678 two cycles after acceptance, a_done=0.
REQ-032 Assert reset in ISSUE of A read -> csb=8'hFF immediately, no a_done, next A request accepted in first IDLE cycle after release.
REQ-033 A write mask 4'h0 -> ram_wmask=0, web=0 in ISSUE, a_done pulses, a_rdata=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Two-port (core A / host B) arbiter in front of eight single-port SRAM
//   bank macros that share address, data and mask lines. Each access takes
//   three cycles: IDLE (accept), ISSUE (drive the macro), COMPLETE (done
//   pulse and read data).
//
//   Default build: fixed priority to A with a starvation counter that
//   forces a grant to B after STARVE_LIMIT consecutive A grants made while B
//   was waiting.
//   Define SRAM_ARB_RR_EN to get round-robin arbitration instead. In that
//   build the starvation counter and STARVE_LIMIT are not used.

module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,

  input  logic         a_valid,
  output logic         a_ready,
  input  logic         a_we,
  input  logic [11:0]  a_addr,
  input  logic [31:0]  a_wdata,
  input  logic [3:0]   a_wmask,
  output logic         a_done,
  output logic [31:0]  a_rdata,

  input  logic         b_valid,
  output logic         b_ready,
  input  logic         b_we,
  input  logic [11:0]  b_addr,
  input  logic [31:0]  b_wdata,
  input  logic [3:0]   b_wmask,
  output logic         b_done,
  output logic [31:0]  b_rdata,

  output logic [7:0]   ram_csb,
  output logic         ram_web,
  output logic [8:0]   ram_addr,
  output logic [31:0]  ram_wdata,
  output logic [3:0]   ram_wmask,
  input  logic [255:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_COMPLETE
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  state_t       state;
  state_t       state_next;

  port_t        lat_owner;
  logic         lat_we;
  logic [11:0]  lat_addr;
  logic [31:0]  lat_wdata;
  logic [3:0]   lat_wmask;

  logic         grant_a;
  logic         grant_b;
  logic [2:0]   lat_bank;
  logic [31:0]  bank_word;

`ifdef SRAM_ARB_RR_EN
  port_t        rr_ptr;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]   starve_cnt;
`endif

  assign lat_bank = lat_addr[11:9];

  // Arbitration: only in IDLE and never while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_IDLE && !reset) begin
      if (a_valid && b_valid) begin
`ifdef SRAM_ARB_RR_EN
        if (rr_ptr == PORT_B) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
`else
        if (starve_cnt == LIMIT) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
`endif
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Next-state sequencing: one access every three cycles.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (grant_a || grant_b) state_next = ST_ISSUE;
      ST_ISSUE:    state_next = ST_COMPLETE;
      ST_COMPLETE: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the accepted request; these registers also drive the shared
  // macro address/data/mask lines, which hold between accesses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_owner <= PORT_A;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (grant_a) begin
      lat_owner <= PORT_A;
      lat_we    <= a_we;
      lat_addr  <= a_addr;
      lat_wdata <= a_wdata;
      lat_wmask <= a_wmask;
    end else if (grant_b) begin
      lat_owner <= PORT_B;
      lat_we    <= b_we;
      lat_addr  <= b_addr;
      lat_wdata <= b_wdata;
      lat_wmask <= b_wmask;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Round-robin pointer names the port preferred on the next contention.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= PORT_A;
    end else if (grant_a) begin
      rr_ptr <= PORT_B;
    end else if (grant_b) begin
      rr_ptr <= PORT_A;
    end
  end
`else
  // Starvation counter: counts A grants made while B waits, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_b) begin
      starve_cnt <= '0;
    end else if (grant_a && b_valid && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Macro control: chip select and write enable only during ISSUE.
  always_comb begin
    ram_csb = '1;
    ram_web = 1'b1;
    if (state == ST_ISSUE) begin
      ram_csb = ~(8'd1 << lat_bank);
      ram_web = ~lat_we;
    end
  end

  assign ram_addr  = lat_addr[8:0];
  assign ram_wdata = lat_wdata;
  assign ram_wmask = lat_wmask;

  // Select the read word of the latched bank from the wide macro bus.
  always_comb begin
    bank_word = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (lat_bank == 3'(i)) begin
        bank_word = ram_rdata[32*i +: 32];
      end
    end
  end

  // Completion: done pulse to the owner; read data only for reads.
  always_comb begin
    a_done  = 1'b0;
    b_done  = 1'b0;
    a_rdata = '0;
    b_rdata = '0;
    if (state == ST_COMPLETE) begin
      if (lat_owner == PORT_A) begin
        a_done = 1'b1;
        if (!lat_we) a_rdata = bank_word;
      end else begin
        b_done = 1'b1;
        if (!lat_we) b_rdata = bank_word;
      end
    end
  end

endmodule
